db_stream_ctrl: RTL and testbench
=================================

# db_stream_ctrl

Streaming controller for the BLAST database path. It sits directly upstream of the 534-bit `shift2Reg` window register. It accepts 512-bit database words (256 bases, 2 bits per base, earliest base in bits [511:510]) over a valid/ready handshake and drives that register's `load`, `shift` and `inData`. It also produces a per-window strobe and base position, so the downstream seed comparator knows which database offset is currently at the top of `outData`.

## Interface
Parameters:
- `POS_W`, 32, width of `win_pos`.

Ports:
- `clk`, in, 1, single clock; everything sampled on the rising edge.
- `rst`, in, 1, reset: asynchronous, active-high.
- `start`, in, 1, begins one database stream; accepted only in IDLE.
- `s_valid`, in, 1, upstream word valid.
- `s_ready`, out, 1, word accepted this cycle. Equal to `load`.
- `s_data`, in, 512, database word.
- `s_last`, in, 1, final word of the stream; qualified by `s_valid & s_ready`.
- `hold`, in, 1, downstream backpressure; suppresses all `load`/`shift` while high.
- `load`, out, 1, to the shift register.
- `shift`, out, 1, to the shift register.
- `inData`, out, 512, to the shift register; equals `s_data`.
- `win_valid`, out, 1, one-cycle strobe: a new window is on `outData` this cycle.
- `win_pos`, out, POS_W, base index of the top base (`outData[511:510]`) while `win_valid` is high.
- `busy`, out, 1, high outside IDLE.
- `done`, out, 1, one-cycle pulse at end of stream.

## Operation
- Constants: `BASES_PER_WORD` = 256; `MARGIN` = 11 (the 22-bit guard in the shift register).
- `k` is an 9-bit count of shifts since the last load, range 0..256.
- IDLE: all strobes low. `start` moves to LOAD0; clears `win_pos` and `k`.
- LOAD0: when `s_valid & !hold`, drive `load=1`, `shift=0`; set `k`=0.
  - If `s_last`, set the last flag.
  - Go to PRIME.
- PRIME: when `!hold`, drive `shift=1`. After the 11th shift (`k`=11), `win_valid` fires with `win_pos`=0. Go to RUN.
  - These 11 shifts also flush any stale upper 22 bits left in the shift register.
- RUN, when `!hold`:
  - If `k`<256: `shift=1`, `k`+=1, `win_pos`+=1, `win_valid` fires.
  - If `k`==256 and last flag clear: wait for `s_valid`, then `load=1`, `shift=1`, `k`<=1, `win_pos`+=1, `win_valid` fires; latch `s_last`.
  - If `k`==256 and no word is available, no strobe is driven; the window and `win_pos` hold.
  - If `k`==256 and last flag set: stream ends; go to IDLE.
- Window count per stream of W words is 256·W−10. The final `win_pos` is 256·W−11, so the last window holds the final 11 bases.
- `done` fires together with the final `win_valid`. The state is IDLE on the following cycle.
- `start` outside IDLE is ignored. `s_valid` outside LOAD0/RUN-boundary is never acknowledged.
- `win_pos` wraps modulo 2^POS_W; no error is flagged.

## Timing
- `load`, `shift`, `s_ready` and `inData` are combinational from the registered state, `k`, `s_valid` and `hold`.
- `win_valid`, `win_pos` and `done` are registered on the same edge that updates the shift register. They therefore describe `outData` in the cycle they are high.
- Latency: start → LOAD0 is 1 cycle. With `s_valid` already high, the first `win_valid` occurs 13 cycles after `start` is sampled.
- `hold` and a boundary stall both take effect the same cycle: no strobe, no counter change.
- Reset, at any time, asynchronously forces IDLE with `k`=0, `win_pos`=0 and the last flag clear. All outputs read 0: `s_ready`, `load`, `shift`, `win_valid`, `busy`, `done`, and `inData` as well.
- A partially consumed stream is abandoned on reset. The next `start` re-primes.

## Structure
- Shared package `blast_pkg`:
  - `BASES_PER_WORD`, `MARGIN`, `WORD_W`=512.
  - State enum: IDLE, LOAD0, PRIME, RUN.
- No sub-module. The shift register is instantiated beside this block at the top level.

## Test plan
- **One word, no stalls.** Drive `start` with one word carrying `s_last` and base i = i mod 4. Expect 246 `win_valid` strobes with `win_pos` 0..245. `outData[511:510]` equals base `win_pos` at every strobe. `done` fires with pos 245.
- **Boundary stall.** Send two words, holding `s_valid` low for 5 cycles at the `k`=256 boundary. Expect no strobes and `outData` frozen during the gap. Then a single `load&shift` cycle. Expect 502 strobes total, contiguous positions, and base 256 at top when `win_pos`=256.
- **Backpressure.** Raise `hold` for 3 cycles mid-RUN at `win_pos`=100. Expect `load`/`shift` low and no strobes. Resume at 101 with the sequence unbroken.
- **Reset mid-stream.** Assert `rst` at `win_pos`=150 of a 3-word stream. Outputs go to 0 immediately. A new `start` with fresh data yields `win_pos`=0 with correct top base, and no stale bits appear in the first window.
- **Start with no data.** Pulse `start` with `s_valid` low for 10 cycles. Expect `busy`=1 in LOAD0 and no `s_ready`. A second `start` while busy is ignored. The stream proceeds normally once `s_valid` rises.

Source files
------------

// File: rtl/blast_pkg.sv
// Shared constants and state encoding for the BLAST database streaming path.
package blast_pkg;

    localparam int BASES_PER_WORD = 256;   // 2-bit bases per 512-bit database word
    localparam int MARGIN         = 11;    // bases held in the 22-bit guard of the window register
    localparam int WORD_W         = 512;   // database word width
    localparam int K_W            = 9;     // shift counter width, range 0..256

    typedef enum logic [1:0] {
        IDLE,
        LOAD0,
        PRIME,
        RUN
    } state_t;

endpackage

// File: rtl/db_stream_ctrl.sv
// Streaming controller feeding the 534-bit shift2Reg window register.
// Accepts 512-bit database words, drives load/shift/inData, and reports which
// database base index sits at the top of the window whenever a new one appears.
module db_stream_ctrl
    import blast_pkg::*;
#(
    parameter int POS_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    input  logic              hold,
    output logic              load,
    output logic              shift,
    output logic [WORD_W-1:0] inData,
    output logic              win_valid,
    output logic [POS_W-1:0]  win_pos,
    output logic              busy,
    output logic              done
);

    // k value meaning every base of the current word has been shifted once
    localparam logic [K_W-1:0] K_FULL   = K_W'(BASES_PER_WORD);
    // k value just before the shift that brings base 0 to the top of the window
    localparam logic [K_W-1:0] K_PRIMED = K_W'(MARGIN - 1);
    // k value just before the final shift of a word
    localparam logic [K_W-1:0] K_LAST   = K_W'(BASES_PER_WORD - 1);

    state_t         state_reg;
    logic [K_W-1:0] k_reg;
    logic           last_reg;

    // Register-control decode: a new word is taken only in LOAD0 or at the
    // k=256 boundary of a non-final word; hold freezes everything.
    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        case (state_reg)
            LOAD0: begin
                load = s_valid & ~hold;
            end
            PRIME: begin
                shift = ~hold;
            end
            RUN: begin
                if (k_reg != K_FULL) begin
                    shift = ~hold;
                end else if (!last_reg) begin
                    // Boundary reload shifts in the same cycle so the window stays contiguous
                    load  = s_valid & ~hold;
                    shift = s_valid & ~hold;
                end
            end
            default: begin
                load  = 1'b0;
                shift = 1'b0;
            end
        endcase
    end

    assign s_ready = load;
    assign busy    = (state_reg != IDLE);
    assign inData  = busy ? s_data : '0;

    // Stream sequencing; window strobe, position and done are registered on
    // the same edge that moves the shift register so they describe outData.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            last_reg  <= 1'b0;
            win_valid <= 1'b0;
            win_pos   <= '0;
            done      <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            done      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= LOAD0;
                        k_reg     <= '0;
                        win_pos   <= '0;
                        last_reg  <= 1'b0;
                    end
                end
                LOAD0: begin
                    if (load) begin
                        k_reg     <= '0;
                        last_reg  <= s_last;
                        state_reg <= PRIME;
                    end
                end
                PRIME: begin
                    if (shift) begin
                        k_reg <= k_reg + K_W'(1);
                        if (k_reg == K_PRIMED) begin
                            win_valid <= 1'b1;
                            win_pos   <= '0;
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (k_reg == K_FULL && last_reg) begin
                        state_reg <= IDLE;
                    end else if (shift) begin
                        win_valid <= 1'b1;
                        win_pos   <= win_pos + POS_W'(1);
                        if (load) begin
                            k_reg    <= K_W'(1);
                            last_reg <= s_last;
                        end else begin
                            k_reg <= k_reg + K_W'(1);
                            // The shift that reaches k=256 on the final word makes the last window
                            if (last_reg && k_reg == K_LAST) begin
                                done <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_db_stream_ctrl.sv
// Self-checking bench for db_stream_ctrl with a behavioural shift2Reg beside it.
module tb_db_stream_ctrl;

    logic         clk;
    logic         rst, start, s_valid, s_last, hold, scramble;
    logic         s_ready, load, shift, win_valid, busy, done;
    logic [511:0] s_data, in_data, out_data;
    logic [31:0]  win_pos;
    logic [533:0] sreg;

    logic [511:0] words [0:3];
    int           nwords;
    int           checks = 0;
    int           errors = 0;

    int           obs_pos [$];
    int           obs_top [$];
    int           obs_cyc [$];
    logic [511:0] first_win;
    int           done_cnt, done_pos, done_nostrobe, stall_viol, hold_viol, ready_viol;
    int           both_cnt, busy_after, latency;
    bit           timed_out, aborted;

    db_stream_ctrl #(.POS_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .hold(hold), .load(load), .shift(shift),
        .inData(in_data), .win_valid(win_valid), .win_pos(win_pos), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 534-bit window register; outData is its top 512 bits
    always @(posedge clk) begin
        if (scramble) sreg <= '1;
        else if (load && shift) sreg <= {sreg[531:512], in_data, 2'b00};
        else if (load) sreg[511:0] <= in_data;
        else if (shift) sreg <= {sreg[531:0], 2'b00};
    end
    assign out_data = sreg[533:22];

    // Reference: database base number pos of the current stream
    function automatic logic [1:0] ref_base(input int pos);
        logic [511:0] w;
        if (pos < 0 || pos >= 256 * nwords) return 2'b00;
        w = words[pos / 256];
        return w[511 - 2 * (pos % 256) -: 2];
    endfunction

    function automatic int first_bad_pos();
        foreach (obs_pos[i]) if (obs_pos[i] != i) return i;
        return -1;
    endfunction

    function automatic int first_bad_top();
        foreach (obs_top[i]) if (obs_top[i] != int'(ref_base(obs_pos[i]))) return i;
        return -1;
    endfunction

    task automatic fill_random(input int nw);
        for (int w = 0; w < nw; w++)
            for (int j = 0; j < 16; j++) words[w][32 * j +: 32] = $urandom;
    endtask

    // Drives one stream and records what the window looked like; no judging here
    task automatic run_stream(input int nw, input int first_gap, input int gap,
                              input int hold_pos, input int hold_len, input bit rand_hold,
                              input bit rand_start, input bit do_start, input int abort_pos);
        int word_idx = 0;
        bit gate = 1'b1;
        int gap_cnt = first_gap;
        int hold_cnt = 0;
        bit moved, acc, got_done = 1'b0;
        logic [511:0] prev_out;
        int p;
        nwords = nw;
        obs_pos.delete(); obs_top.delete(); obs_cyc.delete();
        done_cnt = 0; done_pos = -1; done_nostrobe = 0; stall_viol = 0; hold_viol = 0;
        ready_viol = 0; both_cnt = 0; busy_after = -1; latency = -1;
        timed_out = 1'b0; aborted = 1'b0;
        prev_out = out_data;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            start = (do_start && n == 0) || (rand_start && !got_done && n > 0 && $urandom_range(0, 15) == 0);
            hold = (hold_cnt > 0) || (rand_hold && !got_done && $urandom_range(0, 7) == 0);
            if (hold_cnt > 0) hold_cnt--;
            s_valid = (word_idx < nw) && gate && (gap_cnt == 0);
            s_data = (word_idx < nw) ? words[word_idx] : '0;
            s_last = (word_idx == nw - 1);
            if (gate && gap_cnt > 0) gap_cnt--;
            #1;
            acc = s_ready;
            moved = load | shift;
            if (hold && moved) hold_viol++;
            if (!s_valid && s_ready) ready_viol++;
            if (acc && shift) both_cnt++;
            @(posedge clk);
            #1;
            if (acc) begin
                word_idx++;
                if (word_idx < nw && gap >= 0) gate = 1'b0;
            end
            if (!moved && (win_valid || out_data !== prev_out)) stall_viol++;
            prev_out = out_data;
            if (got_done) begin
                busy_after = busy;
                break;
            end
            if (win_valid) begin
                p = int'(win_pos);
                if (obs_pos.size() == 0) begin
                    first_win = out_data;
                    latency = n + 1;
                end
                obs_pos.push_back(p);
                obs_top.push_back(int'(out_data[511:510]));
                obs_cyc.push_back(n);
                if (p % 256 == 245 && !gate) begin
                    gate = 1'b1;
                    gap_cnt = gap;
                end
                if (p == hold_pos) hold_cnt = hold_len;
                if (done) begin
                    done_cnt++;
                    done_pos = p;
                    got_done = 1'b1;
                end
                if (p == abort_pos) begin
                    aborted = 1'b1;
                    break;
                end
            end else if (done) begin
                done_nostrobe++;
            end
        end
        if (!got_done && !aborted) timed_out = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        if (!aborted) s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; s_valid = 1'b1; s_last = 1'b0; hold = 1'b0; scramble = 1'b1;
        s_data = {16{32'hA5C3_5A3C}};
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load); end
        checks++; if (shift !== 1'b0) begin errors++; $display("FAIL reset_shift: got %b expected 0", shift); end
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (win_pos !== 32'd0) begin errors++; $display("FAIL reset_win_pos: got %0d expected 0", win_pos); end
        checks++; if (in_data !== 512'd0) begin errors++; $display("FAIL reset_inData: got %h expected 0", in_data[511:448]); end
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0;
        rst = 1'b0; scramble = 1'b0;
        $display("reset: outputs checked under reset");
    endtask

    task automatic test_one_word();
        int bad;
        for (int b = 0; b < 256; b++) words[0][511 - 2 * b -: 2] = 2'(b % 4);
        run_stream(1, 0, 0, -1, 0, 1'b0, 1'b0, 1'b1, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL one_word_timeout: done not seen within cycle budget"); end
        checks++; if (obs_pos.size() != 246) begin errors++; $display("FAIL one_word_count: got %0d windows expected 246", obs_pos.size()); end
        bad = first_bad_pos();
        checks++; if (bad >= 0) begin errors++; $display("FAIL one_word_pos: window %0d got win_pos %0d expected %0d", bad, obs_pos[bad], bad); end
        bad = first_bad_top();
        checks++; if (bad >= 0) begin errors++; $display("FAIL one_word_top: pos %0d got base %0d expected %0d", obs_pos[bad], obs_top[bad], ref_base(obs_pos[bad])); end
        checks++; if (done_cnt != 1 || done_pos != 245 || done_nostrobe != 0) begin errors++; $display("FAIL one_word_done: got %0d pulses at pos %0d (%0d without strobe) expected 1 at 245", done_cnt, done_pos, done_nostrobe); end
        checks++; if (latency != 13) begin errors++; $display("FAIL one_word_latency: got %0d cycles expected 13", latency); end
        checks++; if (busy_after != 0) begin errors++; $display("FAIL one_word_idle: busy after done got %0d expected 0", busy_after); end
        checks++; if (first_win !== words[0]) begin errors++; $display("FAIL one_word_first_window: got %h expected %h", first_win[511:448], words[0][511:448]); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL one_word_stall: got %0d unexpected window changes expected 0", stall_viol); end
        $display("one_word: %0d windows, last pos %0d, latency %0d", obs_pos.size(), done_pos, latency);
    endtask

    task automatic test_boundary_stall();
        int bad;
        fill_random(2);
        run_stream(2, 0, 5, -1, 0, 1'b0, 1'b0, 1'b1, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: done not seen within cycle budget"); end
        checks++; if (obs_pos.size() != 502) begin errors++; $display("FAIL stall_count: got %0d windows expected 502", obs_pos.size()); end
        bad = first_bad_pos();
        checks++; if (bad >= 0) begin errors++; $display("FAIL stall_pos: window %0d got win_pos %0d expected %0d", bad, obs_pos[bad], bad); end
        bad = first_bad_top();
        checks++; if (bad >= 0) begin errors++; $display("FAIL stall_top: pos %0d got base %0d expected %0d", obs_pos[bad], obs_top[bad], ref_base(obs_pos[bad])); end
        checks++;
        if (obs_top.size() <= 256 || obs_top[256] != int'(words[1][511:510])) begin
            errors++; $display("FAIL stall_base256: got %0d expected %0d", (obs_top.size() > 256) ? obs_top[256] : -1, words[1][511:510]);
        end
        checks++;
        if (obs_cyc.size() <= 246 || obs_cyc[246] - obs_cyc[245] != 6) begin
            errors++; $display("FAIL stall_gap: got %0d cycles between pos 245 and 246 expected 6", (obs_cyc.size() > 246) ? obs_cyc[246] - obs_cyc[245] : -1);
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_frozen: got %0d window changes without load/shift expected 0", stall_viol); end
        checks++; if (both_cnt != 1) begin errors++; $display("FAIL stall_load_shift: got %0d load&shift cycles expected 1", both_cnt); end
        checks++; if (done_cnt != 1 || done_pos != 501) begin errors++; $display("FAIL stall_done: got %0d pulses at pos %0d expected 1 at 501", done_cnt, done_pos); end
        $display("boundary_stall: %0d windows, gap %0d cycles", obs_pos.size(), (obs_cyc.size() > 246) ? obs_cyc[246] - obs_cyc[245] : -1);
    endtask

    task automatic test_backpressure();
        int bad;
        fill_random(1);
        run_stream(1, 0, 0, 100, 3, 1'b0, 1'b0, 1'b1, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL hold_timeout: done not seen within cycle budget"); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL hold_moves: got %0d load/shift cycles under hold expected 0", hold_viol); end
        checks++;
        if (obs_cyc.size() <= 101 || obs_cyc[101] - obs_cyc[100] != 4) begin
            errors++; $display("FAIL hold_gap: got %0d cycles between pos 100 and 101 expected 4", (obs_cyc.size() > 101) ? obs_cyc[101] - obs_cyc[100] : -1);
        end
        bad = first_bad_pos();
        checks++; if (bad >= 0 || obs_pos.size() != 246) begin errors++; $display("FAIL hold_pos: %0d windows, first break at %0d, expected 246 contiguous", obs_pos.size(), bad); end
        bad = first_bad_top();
        checks++; if (bad >= 0) begin errors++; $display("FAIL hold_top: pos %0d got base %0d expected %0d", obs_pos[bad], obs_top[bad], ref_base(obs_pos[bad])); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL hold_frozen: got %0d window changes without load/shift expected 0", stall_viol); end
        $display("backpressure: %0d windows, resume after %0d cycles", obs_pos.size(), (obs_cyc.size() > 101) ? obs_cyc[101] - obs_cyc[100] : -1);
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_random(3);
        run_stream(3, 0, -1, -1, 0, 1'b0, 1'b0, 1'b1, 150);
        checks++; if (!aborted || obs_pos.size() != 151) begin errors++; $display("FAIL rstmid_reach: got %0d windows before reset expected 151", obs_pos.size()); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, load, shift, win_valid, busy, done} !== 6'b0) begin
            errors++; $display("FAIL rstmid_strobes: got ready/load/shift/wv/busy/done=%b expected 000000", {s_ready, load, shift, win_valid, busy, done});
        end
        checks++; if (win_pos !== 32'd0 || in_data !== 512'd0) begin errors++; $display("FAIL rstmid_data: got win_pos %0d inData %h expected 0 and 0", win_pos, in_data[511:448]); end
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        fill_random(1);
        run_stream(1, 0, 0, -1, 0, 1'b0, 1'b0, 1'b1, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL rstmid_timeout: done not seen within cycle budget"); end
        checks++; if (first_win !== words[0]) begin errors++; $display("FAIL rstmid_first_window: got %h expected %h", first_win[511:448], words[0][511:448]); end
        checks++; if (obs_pos.size() == 0 || obs_pos[0] != 0 || latency != 13) begin errors++; $display("FAIL rstmid_restart: got first pos %0d latency %0d expected 0 and 13", (obs_pos.size() > 0) ? obs_pos[0] : -1, latency); end
        bad = first_bad_pos();
        checks++; if (bad >= 0 || obs_pos.size() != 246) begin errors++; $display("FAIL rstmid_pos: %0d windows, first break at %0d, expected 246 contiguous", obs_pos.size(), bad); end
        $display("reset_mid: restart gave %0d windows", obs_pos.size());
    endtask

    task automatic test_no_data();
        int busy_bad = 0, ready_bad = 0, bad;
        @(negedge clk);
        start = 1'b1; s_valid = 1'b0; hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 4);
            #1;
            if (busy !== 1'b1) busy_bad++;
            if (s_ready !== 1'b0) ready_bad++;
        end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL nodata_busy: got %0d cycles with busy low expected 0", busy_bad); end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL nodata_ready: got %0d cycles with s_ready high expected 0", ready_bad); end
        fill_random(2);
        run_stream(2, 0, 0, -1, 0, 1'b0, 1'b0, 1'b0, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL nodata_timeout: done not seen within cycle budget"); end
        checks++; if (first_win !== words[0]) begin errors++; $display("FAIL nodata_first_window: got %h expected %h", first_win[511:448], words[0][511:448]); end
        bad = first_bad_pos();
        checks++; if (bad >= 0 || obs_pos.size() != 502) begin errors++; $display("FAIL nodata_pos: %0d windows, first break at %0d, expected 502 contiguous", obs_pos.size(), bad); end
        checks++; if (done_cnt != 1 || done_pos != 501) begin errors++; $display("FAIL nodata_done: got %0d pulses at pos %0d expected 1 at 501", done_cnt, done_pos); end
        $display("no_data: %0d windows after late data", obs_pos.size());
    endtask

    task automatic test_random();
        int bad, nw, gap, exp_cnt;
        for (int r = 0; r < 3; r++) begin
            nw = $urandom_range(1, 3);
            gap = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 4));
            exp_cnt = 256 * nw - 10;
            fill_random(nw);
            run_stream(nw, $urandom_range(0, 3), gap, -1, 0, 1'b1, 1'b1, 1'b1, -1);
            checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: done not seen within cycle budget", r); end
            checks++; if (obs_pos.size() != exp_cnt) begin errors++; $display("FAIL rand%0d_count: got %0d windows expected %0d", r, obs_pos.size(), exp_cnt); end
            bad = first_bad_pos();
            checks++; if (bad >= 0) begin errors++; $display("FAIL rand%0d_pos: window %0d got win_pos %0d expected %0d", r, bad, obs_pos[bad], bad); end
            bad = first_bad_top();
            checks++; if (bad >= 0) begin errors++; $display("FAIL rand%0d_top: pos %0d got base %0d expected %0d", r, obs_pos[bad], obs_top[bad], ref_base(obs_pos[bad])); end
            checks++; if (done_cnt != 1 || done_pos != exp_cnt - 1) begin errors++; $display("FAIL rand%0d_done: got %0d pulses at pos %0d expected 1 at %0d", r, done_cnt, done_pos, exp_cnt - 1); end
            checks++; if (hold_viol != 0 || stall_viol != 0 || ready_viol != 0) begin errors++; $display("FAIL rand%0d_handshake: got hold %0d stall %0d ready %0d violations expected 0", r, hold_viol, stall_viol, ready_viol); end
            checks++; if (busy_after != 0) begin errors++; $display("FAIL rand%0d_idle: busy after done got %0d expected 0", r, busy_after); end
            $display("random %0d: %0d words gap %0d, %0d windows", r, nw, gap, obs_pos.size());
        end
    endtask

    initial begin
        test_reset();
        test_one_word();
        test_boundary_stall();
        test_backpressure();
        test_reset_mid();
        test_no_data();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
